// File: rtl/mem_port_arbiter.sv
// Arbitrates a single fixed-latency memory port between instruction fetch (I) and load/store (D).
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int LAT        = 1,
    parameter int MAX_D_WINS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [31:0] m_rdata
`ifdef ARB_STATS_EN
   ,output logic [15:0] stat_i_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_conflicts
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_W  = 4'(LAT);
    localparam logic [3:0] MAX_DW = 4'(MAX_D_WINS);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        sel_i, sel_we;
    logic        decide, win_i;
    logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;

    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        win_i     = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (i_req || d_req) begin
                    decide    = 1'b1;
                    win_i     = i_req && (!d_req || (starve_cnt == MAX_DW));
                    state_nxt = S_CMD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CMD:   state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == LAT_W) state_nxt = S_RESP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            starve_cnt <= 4'd0;
            sel_i      <= 1'b0;
            sel_we     <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (decide) begin
                sel_i   <= win_i;
                sel_we  <= !win_i && d_we;
                addr_q  <= win_i ? i_addr : d_addr;
                wdata_q <= win_i ? 32'd0 : d_wdata;
                // I waiting behind a D grant is what builds up starvation
                if (win_i || !i_req) starve_cnt <= 4'd0;
                else                 starve_cnt <= starve_cnt + 4'd1;
            end
            if (state == S_CMD) wait_cnt <= 4'd1;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 4'd1;
            if (state == S_WAIT && wait_cnt == LAT_W) begin
                if (sel_i)       i_rdata_q <= m_rdata;
                else if (sel_we) d_rdata_q <= 32'd0;
                else             d_rdata_q <= m_rdata;
            end
        end
    end

    assign i_gnt    = (state == S_CMD) && sel_i;
    assign d_gnt    = (state == S_CMD) && !sel_i;
    assign m_rd     = (state == S_CMD) && !sel_we;
    assign m_wr     = (state == S_CMD) && sel_we;
    assign i_rvalid = (state == S_RESP) && sel_i;
    assign d_rvalid = (state == S_RESP) && !sel_i;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_grants  <= 16'd0;
            stat_d_grants  <= 16'd0;
            stat_conflicts <= 16'd0;
        end else begin
            if (i_gnt && stat_i_grants != 16'hFFFF) stat_i_grants <= stat_i_grants + 16'd1;
            if (d_gnt && stat_d_grants != 16'hFFFF) stat_d_grants <= stat_d_grants + 16'd1;
            if (decide && i_req && d_req && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed scenarios.
// Build with ARB_STATS_EN defined to also check the statistics counters.
module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_rd, m_wr;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] stat_i_grants, stat_d_grants, stat_conflicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mem_port_arbiter #(.LAT(LAT), .MAX_D_WINS(MAXW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr), .m_rdata(m_rdata)
`ifdef ARB_STATS_EN
       ,.stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: word k holds C0DE0000|k until written; reads return LAT cycles after m_rd
    logic [31:0] mem [4096];
    logic [31:0] rd_pipe [LAT];
    bit          mem_ready;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 32'hC0DE0000 | 32'(k);
            mem_ready <= 1'b1;
        end else if (m_wr) begin
            mem[m_addr[13:2]] <= m_wdata;
        end
        rd_pipe[0] <= (mem_ready && m_rd) ? mem[m_addr[13:2]] : 32'hBAD0BAD0;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign m_rdata = rd_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s at cycle %0d: got no event, expected one within budget", name, cyc);
    endtask

    // Transaction-level model: each decision schedules a command one cycle later and a
    // response LAT+2 cycles later; the next decision may happen in the response cycle.
    logic [31:0] shadow [4096];
    bit          model_valid = 1'b0;
    int          next_dec, cmd_c, resp_c, starve;
    bit          pend_i, pend_we;
    logic [31:0] pend_data, h_addr, h_wdata, h_irdata, h_drdata;
    int          st_i, st_d, st_c;

    always @(negedge clk) begin
        bit e_cmd, e_resp, w_i;
        e_cmd  = model_valid && (cyc == cmd_c);
        e_resp = model_valid && (cyc == resp_c);
        if (model_valid) begin
            if (e_resp) begin
                if (pend_i) h_irdata = pend_data;
                else        h_drdata = pend_data;
            end
            checkOutput("i_gnt",    32'(i_gnt),    32'(e_cmd && pend_i));
            checkOutput("d_gnt",    32'(d_gnt),    32'(e_cmd && !pend_i));
            checkOutput("m_rd",     32'(m_rd),     32'(e_cmd && !pend_we));
            checkOutput("m_wr",     32'(m_wr),     32'(e_cmd && pend_we));
            checkOutput("i_rvalid", 32'(i_rvalid), 32'(e_resp && pend_i));
            checkOutput("d_rvalid", 32'(d_rvalid), 32'(e_resp && !pend_i));
            checkOutput("m_addr",   m_addr,  h_addr);
            checkOutput("m_wdata",  m_wdata, h_wdata);
            checkOutput("i_rdata",  i_rdata, h_irdata);
            checkOutput("d_rdata",  d_rdata, h_drdata);
`ifdef ARB_STATS_EN
            checkOutput("stat_i_grants",  32'(stat_i_grants),  32'(st_i));
            checkOutput("stat_d_grants",  32'(stat_d_grants),  32'(st_d));
            checkOutput("stat_conflicts", 32'(stat_conflicts), 32'(st_c));
`endif
        end
        if (rst) begin
            if (!model_valid)
                for (int k = 0; k < 4096; k++) shadow[k] = 32'hC0DE0000 | 32'(k);
            model_valid = 1'b1;
            next_dec = cyc + 1; cmd_c = -1; resp_c = -1; starve = 0;
            pend_i = 1'b0; pend_we = 1'b0; pend_data = 32'd0;
            h_addr = 32'd0; h_wdata = 32'd0; h_irdata = 32'd0; h_drdata = 32'd0;
            st_i = 0; st_d = 0; st_c = 0;
        end else if (model_valid) begin
            if (e_cmd && pend_i  && st_i < 65535) st_i++;
            if (e_cmd && !pend_i && st_d < 65535) st_d++;
            if (cyc >= next_dec && (i_req || d_req)) begin
                if (i_req && d_req && st_c < 65535) st_c++;
                w_i = i_req && (!d_req || starve == MAXW);
                starve = (!w_i && i_req) ? starve + 1 : 0;
                pend_i  = w_i;
                pend_we = !w_i && d_we;
                h_addr  = w_i ? i_addr : d_addr;
                h_wdata = w_i ? 32'd0 : d_wdata;
                if (w_i)          pend_data = shadow[i_addr[13:2]];
                else if (d_we)    pend_data = 32'd0;
                else              pend_data = shadow[d_addr[13:2]];
                if (pend_we) shadow[d_addr[13:2]] = d_wdata;
                cmd_c    = cyc + 1;
                resp_c   = cyc + 2 + LAT;
                next_dec = resp_c;
            end
        end
    end

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk); #1;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    // which: 0=i_gnt 1=d_gnt 2=i_rvalid 3=d_rvalid; returns cycle seen or -1
    task automatic waitSig(input int which, input int budget, input string name, output int at);
        logic s;
        at = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            case (which)
                0: s = i_gnt;
                1: s = d_gnt;
                2: s = i_rvalid;
                default: s = d_rvalid;
            endcase
            if (s) begin at = cyc; return; end
        end
        reportTimeout(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, g, r, k, cnt;
        logic [9:0] seq;
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_m_addr", m_addr, 32'd0);
        checkOutput("reset_i_rdata", i_rdata, 32'd0);

        // I-only read
        applyStimulus(1, 32'h1000, 0, 0, 0, 0); n = cyc;
        waitSig(0, 20, "t1_gnt", g);
        checkOutput("t1_gnt_cycle", 32'(g), 32'(n + 1));
        checkOutput("t1_m_addr", m_addr, 32'h1000);
        checkOutput("t1_m_rd", 32'(m_rd), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(2, 20, "t1_rvalid", r);
        checkOutput("t1_rvalid_cycle", 32'(r), 32'(n + 2 + LAT));
        checkOutput("t1_i_rdata", i_rdata, 32'hC0DE0400);

        // D write then read back
        applyStimulus(0, 0, 1, 1, 32'h2004, 32'hDEADBEEF);
        waitSig(1, 20, "t2_wr_gnt", g);
        checkOutput("t2_m_wr", 32'(m_wr), 32'd1);
        checkOutput("t2_m_rd", 32'(m_rd), 32'd0);
        checkOutput("t2_m_wdata", m_wdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(3, 20, "t2_wr_rvalid", r);
        checkOutput("t2_wr_d_rdata", d_rdata, 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h2004, 0);
        waitSig(1, 20, "t2_rd_gnt", g);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(3, 20, "t2_rd_rvalid", r);
        checkOutput("t2_rd_d_rdata", d_rdata, 32'hDEADBEEF);

        // Simultaneous first request: D first, I at the following decision
        applyStimulus(1, 32'h1010, 1, 0, 32'h2004, 0); n = cyc;
        waitSig(1, 20, "t3_d_gnt", g);
        checkOutput("t3_d_gnt_cycle", 32'(g), 32'(n + 1));
        applyStimulus(1, 32'h1010, 0, 0, 0, 0);
        waitSig(0, 20, "t3_i_gnt", g);
        checkOutput("t3_i_gnt_cycle", 32'(g), 32'(n + 3 + LAT));
        checkOutput("t3_m_addr", m_addr, 32'h1010);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(2, 20, "t3_rvalid", r);
        checkOutput("t3_i_rdata", i_rdata, 32'hC0DE0404);

        // Starvation: both held high, expect D,D,D,D,I,D,D,D,D,I
        applyStimulus(1, 32'h1000, 1, 0, 32'h2004, 0);
        k = 0; seq = '0;
        for (int c = 0; c < 200 && k < 10; c++) begin
            @(negedge clk);
            if (i_gnt) begin seq[k] = 1'b1; k++; end
            else if (d_gnt) begin seq[k] = 1'b0; k++; end
        end
        if (k < 10) reportTimeout("t4_grants");
        checkOutput("t4_grant_order", 32'(seq), 32'h210);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(2, 20, "t4_last_rvalid", r);

        // Reset during WAIT drops the access
        applyStimulus(1, 32'h1020, 0, 0, 0, 0);
        waitSig(0, 20, "t5_gnt", g);
        @(posedge clk); #1 i_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_m_addr", m_addr, 32'd0);
        checkOutput("t5_i_rdata", i_rdata, 32'd0);
        checkOutput("t5_d_rdata", d_rdata, 32'd0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (i_rvalid || d_rvalid) cnt++;
        end
        checkOutput("t5_no_rvalid", 32'(cnt), 32'd0);
        applyStimulus(1, 32'h1000, 0, 0, 0, 0); n = cyc;
        waitSig(0, 20, "t5_new_gnt", g);
        checkOutput("t5_new_gnt_cycle", 32'(g), 32'(n + 1));
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitSig(2, 20, "t5_new_rvalid", r);
        checkOutput("t5_new_i_rdata", i_rdata, 32'hC0DE0400);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
